noise_sync_check: RTL and testbench

Receive-side checker for the 24-bit LFSR noise stream produced by the noise generator.
- Accepts one 24-bit sample per valid/ready handshake.
- Self-synchronises to the stream, then predicts every following sample.
- Reports lock state and counts mismatches.
- Sits on the noise path in loopback/BIST, or after any transport of noise samples, to prove the stream arrives intact.

---
 rtl/noise_pkg.sv | 28 ++
 rtl/noise_sync_check.sv | 147 ++++++++++++++
 tb/tb_noise_sync_check.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/noise_pkg.sv
// noise_pkg: the one place that defines the 24-bit noise LFSR.
// The generator and the checker both import it, so they always agree on
// the polynomial, the seed and the checker state encoding.
//   NOISE_W       : sample width
//   LFSR_TAP_MASK : feedback taps at bits 23, 3, 2 and 0
//   LFSR_SEED     : generator start value
//   lfsr_step()   : one shift of the register, new bit enters at bit 0
//   state_e       : checker FSM states
package noise_pkg;

    localparam int NOISE_W = 24;

    // Bits 23, 3, 2, 0 are XORed to form the feedback bit.
    localparam logic [NOISE_W-1:0] LFSR_TAP_MASK = 24'h80000D;

    localparam logic [NOISE_W-1:0] LFSR_SEED = 24'h8964CE;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic logic [NOISE_W-1:0] lfsr_step(input logic [NOISE_W-1:0] x);
        return {x[NOISE_W-2:0], ^(x & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/noise_sync_check.sv
// noise_sync_check: receive-side checker for the 24-bit LFSR noise stream.
// It seeds a predictor from the first non-zero sample, needs LOCK_COUNT
// correct predictions in a row to declare lock, then free-runs the
// predictor (flywheel) and counts every mismatch. LOSS_COUNT consecutive
// mismatches while locked drop it back to hunting.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   valid_i        : noise_i holds a sample
//   ready_o        : always 1 once out of reset (no backpressure)
//   noise_i        : received sample
//   clear_i        : synchronous clear of err_count_o (wins over increment)
//   locked_o       : registered lock indication
//   err_o          : one-cycle pulse per mismatch seen while locked
//   err_count_o    : saturating mismatch count
module noise_sync_check
    import noise_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [NOISE_W-1:0]   noise_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(LOSS_COUNT + 1);

    state_e                 state_q, state_d;
    logic [NOISE_W-1:0]     pred_q, pred_d;
    logic [MW-1:0]          match_q, match_d;
    logic [SW-1:0]          miss_q, miss_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   ready_q;

    logic accept;
    logic sample_zero;
    logic hit;
    logic locked_miss;

    assign accept      = valid_i & ready_q;
    assign sample_zero = (noise_i == '0);
    assign hit         = (noise_i == pred_q);
    // The predictor is never zero while locked, so a zero sample always
    // lands here as a mismatch.
    assign locked_miss = accept && (state_q == LOCKED) && !hit;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= HUNT;
            pred_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            ready_q  <= 1'b1;
        end
    end

    // Next-state logic: everything holds unless a sample is accepted.
    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (!sample_zero) begin
                        pred_d  = lfsr_step(noise_i);
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (sample_zero) begin
                        state_d = HUNT;
                    end else if (hit) begin
                        pred_d  = lfsr_step(noise_i);
                        match_d = match_q + 1'b1;
                        if (int'(match_q) + 1 == LOCK_COUNT) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        // Reseed from the received sample and start over.
                        pred_d  = lfsr_step(noise_i);
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: advance from our own prediction so a
                    // corrupted sample cannot knock the alignment off.
                    pred_d = lfsr_step(pred_q);
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                        if (int'(miss_q) + 1 == LOSS_COUNT) begin
                            state_d = HUNT;
                            miss_d  = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output logic (values registered in the state register process)
    always_comb begin
        err_d    = locked_miss;
        locked_d = (state_d == LOCKED);
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (locked_miss && (cnt_q != {ERR_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign ready_o     = ready_q;
    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign err_count_o = cnt_q;

endmodule

// File: tb/tb_noise_sync_check.sv
module tb_noise_sync_check;

    localparam int CW = 4;
    localparam logic [23:0] SEED = 24'h8964CE;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [23:0]   noise_i = '0;
    logic          clear_i = 1'b0;
    logic          locked_o;
    logic          err_o;
    logic [CW-1:0] err_count_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] gen;

    noise_sync_check #(
        .LOCK_COUNT(4),
        .LOSS_COUNT(3),
        .ERR_CNT_W (CW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .noise_i    (noise_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] gen_step(input logic [23:0] x);
        return {x[22:0], x[23] ^ x[3] ^ x[2] ^ x[0]};
    endfunction

    // Apply inputs on the falling edge, look at outputs 1 time unit after
    // the next rising edge.
    task automatic drive(input logic v, input logic [23:0] d, input logic clr);
        @(negedge clk_i);
        valid_i = v;
        noise_i = d;
        clear_i = clr;
        @(posedge clk_i);
        #1;
        $display("txn t=%0t v=%0b d=%06h clr=%0b -> rdy=%0b lock=%0b err=%0b cnt=%0d",
                 $time, v, d, clr, ready_o, locked_o, err_o, err_count_o);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        gen = SEED;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b1; noise_i = SEED; clear_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %0b want 0", ready_o); end
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", locked_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err_o); end
        n_cmp++; if (err_count_o !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", err_count_o); end
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %0b want 1", ready_o); end
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL locked_after_reset: got %0b want 0", locked_o); end
        gen = SEED;
    endtask

    task automatic test_lock();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, gen, 1'b0);
            gen = gen_step(gen);
            n_cmp++; if (locked_o !== (k >= 5)) begin n_bad++; $display("FAIL lock_k%0d: got %0b want %0b", k, locked_o, k >= 5); end
            n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL lock_err_k%0d: got %0b want 0", k, err_o); end
        end
        n_cmp++; if (err_count_o !== 4'd0) begin n_bad++; $display("FAIL lock_cnt: got %0d want 0", err_count_o); end
    endtask

    task automatic test_single_error();
        drive(1'b1, gen ^ 24'h1, 1'b0);
        gen = gen_step(gen);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL single_err_pulse: got %0b want 1", err_o); end
        n_cmp++; if (err_count_o !== 4'd1) begin n_bad++; $display("FAIL single_cnt: got %0d want 1", err_count_o); end
        n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL single_locked: got %0b want 1", locked_o); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, gen, 1'b0);
            gen = gen_step(gen);
            n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL single_after_err%0d: got %0b want 0", k, err_o); end
            n_cmp++; if (err_count_o !== 4'd1) begin n_bad++; $display("FAIL single_after_cnt%0d: got %0d want 1", k, err_count_o); end
        end
    endtask

    task automatic test_loss_relock();
        drive(1'b0, 24'hABCDEF, 1'b1);
        n_cmp++; if (err_count_o !== 4'd0) begin n_bad++; $display("FAIL idle_clear: got %0d want 0", err_count_o); end
        n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL clear_keeps_lock: got %0b want 1", locked_o); end
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, gen ^ 24'h1, 1'b0);
            gen = gen_step(gen);
            n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL loss_err%0d: got %0b want 1", k, err_o); end
            n_cmp++; if (err_count_o !== 4'(k)) begin n_bad++; $display("FAIL loss_cnt%0d: got %0d want %0d", k, err_count_o, k); end
            n_cmp++; if (locked_o !== (k < 3)) begin n_bad++; $display("FAIL loss_locked%0d: got %0b want %0b", k, locked_o, k < 3); end
        end
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, gen, 1'b0);
            gen = gen_step(gen);
            n_cmp++; if (locked_o !== (k == 5)) begin n_bad++; $display("FAIL relock_k%0d: got %0b want %0b", k, locked_o, k == 5); end
            n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL relock_err%0d: got %0b want 0", k, err_o); end
        end
    endtask

    task automatic test_zeros();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 24'h000000, 1'b0);
            n_cmp++; if (locked_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL zero_hunt%0d: got lock=%0b err=%0b want 0/0", k, locked_o, err_o); end
        end
        // Exactly 5 non-zero accepts after the zeros must lock: the zeros
        // did not seed anything.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, gen, 1'b0);
            gen = gen_step(gen);
            n_cmp++; if (locked_o !== (k == 5)) begin n_bad++; $display("FAIL zero_then_lock%0d: got %0b want %0b", k, locked_o, k == 5); end
        end
        n_cmp++; if (err_count_o !== 4'd0) begin n_bad++; $display("FAIL zero_cnt: got %0d want 0", err_count_o); end
    endtask

    task automatic test_stall();
        logic [19:0] pat;
        int acc;
        pat = 20'b1101_0011_0110_1001_1011;
        acc = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (pat[k]) begin
                drive(1'b1, gen, 1'b0);
                gen = gen_step(gen);
                acc++;
            end else begin
                drive(1'b0, 24'h5A5A5A, 1'b0);
            end
            n_cmp++; if (locked_o !== (acc >= 5)) begin n_bad++; $display("FAIL stall_lock%0d: got %0b want %0b (accepts %0d)", k, locked_o, acc >= 5, acc); end
            n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL stall_err%0d: got %0b want 0", k, err_o); end
        end
    endtask

    task automatic test_saturation();
        int nerr;
        nerr = 0;
        for (int r = 0; r < 10; r++) begin
            for (int b = 0; b < 2; b++) begin
                drive(1'b1, gen ^ 24'h1, 1'b0);
                gen = gen_step(gen);
                nerr++;
                n_cmp++; if (err_count_o !== 4'((nerr > 15) ? 15 : nerr)) begin n_bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", nerr, err_count_o, (nerr > 15) ? 15 : nerr); end
                n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL sat_locked%0d: got %0b want 1", nerr, locked_o); end
            end
            drive(1'b1, gen, 1'b0);
            gen = gen_step(gen);
        end
        n_cmp++; if (err_count_o !== 4'hF) begin n_bad++; $display("FAIL sat_hold: got %0d want 15", err_count_o); end
        drive(1'b1, gen ^ 24'h1, 1'b1);
        gen = gen_step(gen);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL clear_err_pulse: got %0b want 1", err_o); end
        n_cmp++; if (err_count_o !== 4'd0) begin n_bad++; $display("FAIL clear_priority: got %0d want 0", err_count_o); end
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b1; noise_i = gen ^ 24'h1; clear_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if ({ready_o, locked_o, err_o, err_count_o} !== 7'd0) begin n_bad++; $display("FAIL mid_reset: got rdy=%0b lock=%0b err=%0b cnt=%0d want all 0", ready_o, locked_o, err_o, err_count_o); end
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %0b want 1", ready_o); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_zeros();
        test_stall();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
